// File: rtl/pipe_pkg.sv
// Shared definitions for the generic MIPS32 inter-stage buffer: occupancy states,
// NOP control value, per-stage bundle widths and control-field bit positions.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_e;

   localparam int                    CTRL_W_DEF = 8;
   localparam logic [CTRL_W_DEF-1:0] NOP_CTRL   = 8'h00;

   // Data-bundle widths of the four classic stage boundaries
   localparam int IF_ID_W  = 64;
   localparam int ID_EX_W  = 106;
   localparam int EX_MEM_W = 73;
   localparam int MEM_WB_W = 69;

   localparam int CTRL_REG_WRITE = 0;
   localparam int CTRL_MEM_READ  = 1;
   localparam int CTRL_MEM_WRITE = 2;
   localparam int CTRL_BRANCH    = 3;
   localparam int CTRL_JUMP      = 4;
   localparam int CTRL_MEM_TO_REG = 5;
   localparam int CTRL_ALU_SRC   = 6;
   localparam int CTRL_REG_DST   = 7;

endpackage

// File: rtl/pipe_slot.sv
// One entry of a pipeline stage buffer: valid bit, control bundle and data bundle.
// clear_ctrl wins over load; it drops the entry and zeroes its control field.
module pipe_slot #(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 106
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear_ctrl,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   logic              valid_r;
   logic [CTRL_W-1:0] ctrl_r;
   logic [DATA_W-1:0] data_r;

   // Entry register; a clear leaves the data field untouched
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_r <= 1'b0;
         ctrl_r  <= {CTRL_W{1'b0}};
         data_r  <= {DATA_W{1'b0}};
      end else if (clear_ctrl) begin
         valid_r <= 1'b0;
         ctrl_r  <= {CTRL_W{1'b0}};
         data_r  <= data_r;
      end else if (load) begin
         valid_r <= 1'b1;
         ctrl_r  <= d_ctrl;
         data_r  <= d_data;
      end else begin
         valid_r <= valid_r;
         ctrl_r  <= ctrl_r;
         data_r  <= data_r;
      end
   end

   assign valid = valid_r;
   assign ctrl  = ctrl_r;
   assign data  = data_r;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic flow-controlled pipeline stage register with optional two-entry skid
// buffer (registered in_ready), flush/bubble insertion and a saturating stall counter.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 106,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              alive_r;
   logic              in_acc_s;
   logic              out_acc_s;
   logic              head_load_s;
   logic              head_clr_s;
   logic [CTRL_W-1:0] head_d_ctrl_s;
   logic [DATA_W-1:0] head_d_data_s;
   logic              head_valid_s;
   logic [CTRL_W-1:0] head_ctrl_s;
   logic [DATA_W-1:0] head_data_s;
   logic [CNT_W-1:0]  stall_cnt_r;

   assign in_acc_s  = in_valid & in_ready & ~flush;
   assign out_acc_s = head_valid_s & out_ready;

   // Holds in_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alive_r <= 1'b0;
      end else begin
         alive_r <= 1'b1;
      end
   end

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
      .clk        (clk),
      .reset      (reset),
      .load       (head_load_s),
      .clear_ctrl (head_clr_s),
      .d_ctrl     (head_d_ctrl_s),
      .d_data     (head_d_data_s),
      .valid      (head_valid_s),
      .ctrl       (head_ctrl_s),
      .data       (head_data_s)
   );

   generate
      if (SKID != 0) begin : g_skid
         buf_state_e        state_r;
         buf_state_e        state_nxt_s;
         logic              skid_load_s;
         logic              skid_clr_s;
         logic              skid_valid_s;
         logic [CTRL_W-1:0] skid_ctrl_s;
         logic [DATA_W-1:0] skid_data_s;

         pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
            .clk        (clk),
            .reset      (reset),
            .load       (skid_load_s),
            .clear_ctrl (skid_clr_s),
            .d_ctrl     (in_ctrl),
            .d_data     (in_data),
            .valid      (skid_valid_s),
            .ctrl       (skid_ctrl_s),
            .data       (skid_data_s)
         );

         // in_ready depends only on flops, so out_ready never reaches it
         assign in_ready = alive_r & (state_r != FULL);

         // Head refills from the skid slot whenever the skid holds the older entry
         always_comb begin
            if (skid_valid_s) begin
               head_d_ctrl_s = skid_ctrl_s;
               head_d_data_s = skid_data_s;
            end else begin
               head_d_ctrl_s = in_ctrl;
               head_d_data_s = in_data;
            end
         end

         // Occupancy transitions and slot load/clear strobes; flush overrides all
         always_comb begin
            state_nxt_s = state_r;
            head_load_s = 1'b0;
            head_clr_s  = flush;
            skid_load_s = 1'b0;
            skid_clr_s  = flush;
            if (flush) begin
               state_nxt_s = EMPTY;
            end else begin
               case (state_r)
                  EMPTY: begin
                     if (in_acc_s) begin
                        head_load_s = 1'b1;
                        state_nxt_s = ONE;
                     end else begin
                        state_nxt_s = EMPTY;
                     end
                  end
                  ONE: begin
                     if (in_acc_s && out_acc_s) begin
                        head_load_s = 1'b1;
                        state_nxt_s = ONE;
                     end else if (in_acc_s) begin
                        skid_load_s = 1'b1;
                        state_nxt_s = FULL;
                     end else if (out_acc_s) begin
                        head_clr_s  = 1'b1;
                        state_nxt_s = EMPTY;
                     end else begin
                        state_nxt_s = ONE;
                     end
                  end
                  FULL: begin
                     if (out_acc_s) begin
                        head_load_s = 1'b1;
                        skid_clr_s  = 1'b1;
                        state_nxt_s = ONE;
                     end else begin
                        state_nxt_s = FULL;
                     end
                  end
                  default: begin
                     head_clr_s  = 1'b1;
                     skid_clr_s  = 1'b1;
                     state_nxt_s = EMPTY;
                  end
               endcase
            end
         end

         // Occupancy state register
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               state_r <= EMPTY;
            end else begin
               state_r <= state_nxt_s;
            end
         end
      end else begin : g_single
         assign in_ready = alive_r & (~head_valid_s | out_ready);

         // Single slot: a simultaneous take and give reloads instead of clearing
         always_comb begin
            head_d_ctrl_s = in_ctrl;
            head_d_data_s = in_data;
            head_load_s   = in_acc_s;
            if (flush) begin
               head_clr_s = 1'b1;
            end else begin
               head_clr_s = out_acc_s & ~in_acc_s;
            end
         end
      end
   endgenerate

   // Saturating count of stalled cycles; flush does not clear it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (head_valid_s && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign out_valid = head_valid_s;
   assign out_ctrl  = head_ctrl_s & {CTRL_W{head_valid_s}};
   assign out_data  = head_data_s;
   assign stall_cnt = stall_cnt_r;

endmodule
